// File: rtl/mode_ctrl.sv
// Clock-setting mode controller: RUN / SET_HR / SET_MIN / ALARM_HR.
// Optional idle timeout back to RUN is built when MODE_CTRL_TIMEOUT_EN is defined.
module mode_ctrl #(
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_mode,
    input  logic       key_sel,
    input  logic       key_inc,
    input  logic       key_alarm,
    input  logic [3:0] hr_high_timing,
    input  logic [3:0] hr_low_timing,
    input  logic [3:0] min_high_timing,
    input  logic [3:0] min_low_timing,
    output logic       mode,
    output logic       alarm_set,
    output logic [3:0] hr_high_setting,
    output logic [3:0] hr_low_setting,
    output logic [3:0] min_high_setting,
    output logic [3:0] min_low_setting,
    output logic [3:0] hr_high_alarm,
    output logic [3:0] hr_low_alarm,
    output logic       load_time,
    output logic [1:0] edit_field
);

    typedef enum logic [1:0] {RUN, SET_HR, SET_MIN, ALARM_HR} state_t;

    state_t     state;
    logic [3:0] keys;
    logic [3:0] key_q;
    logic [3:0] press;
    logic       p_mode;
    logic       p_alarm;
    logic       p_sel;
    logic       p_inc;
    logic       timeout;

    function automatic logic [7:0] hour_inc(input logic [7:0] h);
        logic [7:0] r;
        if (h == 8'h23)
            r = 8'h00;
        else if (h[3:0] == 4'd9)
            r = {h[7:4] + 4'd1, 4'd0};
        else
            r = {h[7:4], h[3:0] + 4'd1};
        return r;
    endfunction

    function automatic logic [7:0] minute_inc(input logic [7:0] m);
        logic [7:0] r;
        if (m == 8'h59)
            r = 8'h00;
        else if (m[3:0] == 4'd9)
            r = {m[7:4] + 4'd1, 4'd0};
        else
            r = {m[7:4], m[3:0] + 4'd1};
        return r;
    endfunction

    // Display controls per state: {mode, alarm_set, edit_field}.
    function automatic logic [3:0] view(input state_t s);
        logic [3:0] r;
        unique case (s)
            RUN:      r = 4'b1000;
            SET_HR:   r = 4'b0001;
            SET_MIN:  r = 4'b0010;
            ALARM_HR: r = 4'b1111;
        endcase
        return r;
    endfunction

    // Rising-edge detect on all keys, then keep only the highest-priority press.
    always_comb begin
        keys    = {key_mode, key_alarm, key_sel, key_inc};
        press   = keys & ~key_q;
        p_mode  = press[3];
        p_alarm = press[2] & ~press[3];
        p_sel   = press[1] & ~(|press[3:2]);
        p_inc   = press[0] & ~(|press[3:1]);
    end

`ifdef MODE_CTRL_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] idle_cnt;

    // Timeout fires on the idle cycle that would complete TIMEOUT_CYCLES.
    always_comb begin
        timeout = (state != RUN) && (press == 4'd0)
                  && (idle_cnt == CW'(TIMEOUT_CYCLES - 1));
    end

    // Idle counter: restarts on any press and on every state entry.
    always_ff @(posedge clk) begin
        if (rst || state == RUN || (|press) || timeout)
            idle_cnt <= '0;
        else
            idle_cnt <= idle_cnt + CW'(1);
    end
`else
    // No idle counter; the comparison below is constant false.
    always_comb begin
        timeout = (TIMEOUT_CYCLES < 0);
    end
`endif

    // Mode FSM with registered display controls and edit registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= RUN;
            {mode, alarm_set, edit_field} <= view(RUN);
            load_time <= 1'b0;
            key_q     <= 4'hF;
            {hr_high_setting, hr_low_setting}   <= 8'h00;
            {min_high_setting, min_low_setting} <= 8'h00;
            {hr_high_alarm, hr_low_alarm}       <= 8'h00;
        end else begin
            key_q     <= keys;
            load_time <= 1'b0;
            unique case (state)
                RUN: begin
                    if (p_mode) begin
                        state <= SET_HR;
                        {mode, alarm_set, edit_field} <= view(SET_HR);
                        {hr_high_setting, hr_low_setting} <=
                            {hr_high_timing, hr_low_timing};
                        {min_high_setting, min_low_setting} <=
                            {min_high_timing, min_low_timing};
                    end else if (p_alarm) begin
                        state <= ALARM_HR;
                        {mode, alarm_set, edit_field} <= view(ALARM_HR);
                    end
                end
                SET_HR: begin
                    if (p_mode) begin
                        state     <= RUN;
                        load_time <= 1'b1;
                        {mode, alarm_set, edit_field} <= view(RUN);
                    end else if (p_sel) begin
                        state <= SET_MIN;
                        {mode, alarm_set, edit_field} <= view(SET_MIN);
                    end else if (p_inc) begin
                        {hr_high_setting, hr_low_setting} <=
                            hour_inc({hr_high_setting, hr_low_setting});
                    end else if (timeout) begin
                        state <= RUN;
                        {mode, alarm_set, edit_field} <= view(RUN);
                    end
                end
                SET_MIN: begin
                    if (p_mode) begin
                        state     <= RUN;
                        load_time <= 1'b1;
                        {mode, alarm_set, edit_field} <= view(RUN);
                    end else if (p_sel) begin
                        state <= SET_HR;
                        {mode, alarm_set, edit_field} <= view(SET_HR);
                    end else if (p_inc) begin
                        {min_high_setting, min_low_setting} <=
                            minute_inc({min_high_setting, min_low_setting});
                    end else if (timeout) begin
                        state <= RUN;
                        {mode, alarm_set, edit_field} <= view(RUN);
                    end
                end
                ALARM_HR: begin
                    if (p_mode || p_alarm) begin
                        state <= RUN;
                        {mode, alarm_set, edit_field} <= view(RUN);
                    end else if (p_inc) begin
                        {hr_high_alarm, hr_low_alarm} <=
                            hour_inc({hr_high_alarm, hr_low_alarm});
                    end else if (timeout) begin
                        state <= RUN;
                        {mode, alarm_set, edit_field} <= view(RUN);
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mode_ctrl.sv
// Self-checking bench for mode_ctrl: directed vector table, hand sequences,
// and randomized keys against a behavioural model.
module tb_mode_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       key_mode, key_sel, key_inc, key_alarm;
    logic [3:0] hr_high_timing, hr_low_timing;
    logic [3:0] min_high_timing, min_low_timing;
    logic       mode, alarm_set, load_time;
    logic [3:0] hr_high_setting, hr_low_setting;
    logic [3:0] min_high_setting, min_low_setting;
    logic [3:0] hr_high_alarm, hr_low_alarm;
    logic [1:0] edit_field;

    int checks = 0;
    int failures = 0;

    mode_ctrl #(.TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .rst(rst),
        .key_mode(key_mode), .key_sel(key_sel),
        .key_inc(key_inc), .key_alarm(key_alarm),
        .hr_high_timing(hr_high_timing), .hr_low_timing(hr_low_timing),
        .min_high_timing(min_high_timing), .min_low_timing(min_low_timing),
        .mode(mode), .alarm_set(alarm_set),
        .hr_high_setting(hr_high_setting), .hr_low_setting(hr_low_setting),
        .min_high_setting(min_high_setting), .min_low_setting(min_low_setting),
        .hr_high_alarm(hr_high_alarm), .hr_low_alarm(hr_low_alarm),
        .load_time(load_time), .edit_field(edit_field)
    );

    always #5 clk = ~clk;

    // Expected display controls {mode, alarm_set, edit_field}
    localparam logic [3:0] VR = 4'b1000;
    localparam logic [3:0] VH = 4'b0001;
    localparam logic [3:0] VM = 4'b0010;
    localparam logic [3:0] VA = 4'b1111;

    // Key bits {mode, alarm, sel, inc}
    typedef struct {
        logic [3:0]  k;
        logic [15:0] tm;
        logic [3:0]  vw;
        logic [15:0] st;
        logic [7:0]  al;
        logic        ld;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t v(input logic [3:0] k, input logic [15:0] tm,
                               input logic [3:0] vw, input logic [15:0] st,
                               input logic [7:0] al, input logic ld);
        vec_t r;
        r.k = k; r.tm = tm; r.vw = vw; r.st = st; r.al = al; r.ld = ld;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [15:0] act,
                       input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [3:0] vw,
                           input logic [15:0] st, input logic [7:0] al,
                           input logic ld);
        chk({tag, " view"}, {12'd0, mode, alarm_set, edit_field}, {12'd0, vw});
        chk({tag, " setting"}, {hr_high_setting, hr_low_setting,
            min_high_setting, min_low_setting}, st);
        chk({tag, " alarm"}, {8'd0, hr_high_alarm, hr_low_alarm}, {8'd0, al});
        chk({tag, " load_time"}, {15'd0, load_time}, {15'd0, ld});
    endtask

    task automatic drive(input logic r, input logic [3:0] k,
                         input logic [15:0] tm);
        rst = r;
        {key_mode, key_alarm, key_sel, key_inc} = k;
        {hr_high_timing, hr_low_timing, min_high_timing, min_low_timing} = tm;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- behavioural reference model ----------------
    typedef enum {M_RUN, M_HR, M_MIN, M_ALARM} mst_t;
    mst_t m_st;
    int   m_hr, m_min, m_al, m_idle;
    bit   m_ld;
    bit   m_prev[4];

    function automatic logic [7:0] bcd(input int n);
        return {4'(n / 10), 4'(n % 10)};
    endfunction

    function automatic logic [3:0] m_view();
        case (m_st)
            M_RUN:   return VR;
            M_HR:    return VH;
            M_MIN:   return VM;
            default: return VA;
        endcase
    endfunction

    task automatic m_step(input logic r, input logic [3:0] k,
                          input int th, input int tmn);
        int win;
        bit any;
        m_ld = 0;
        if (r) begin
            m_st = M_RUN; m_hr = 0; m_min = 0; m_al = 0; m_idle = 0;
            for (int i = 0; i < 4; i++) m_prev[i] = 1;
            return;
        end
        win = -1;
        any = 0;
        // index 3 = mode, 2 = alarm, 1 = sel, 0 = inc; scan by priority
        for (int i = 3; i >= 0; i--) begin
            if (k[i] && !m_prev[i]) begin
                any = 1;
                if (win < 0) win = i;
            end
        end
        for (int i = 0; i < 4; i++) m_prev[i] = k[i];
        if (any) begin
            m_idle = 0;
            case (m_st)
                M_RUN: begin
                    if (win == 3) begin
                        m_st = M_HR; m_hr = th; m_min = tmn;
                    end else if (win == 2) m_st = M_ALARM;
                end
                M_HR: begin
                    if (win == 3) begin m_st = M_RUN; m_ld = 1; end
                    else if (win == 1) m_st = M_MIN;
                    else if (win == 0) m_hr = (m_hr + 1) % 24;
                end
                M_MIN: begin
                    if (win == 3) begin m_st = M_RUN; m_ld = 1; end
                    else if (win == 1) m_st = M_HR;
                    else if (win == 0) m_min = (m_min + 1) % 60;
                end
                default: begin
                    if (win == 3 || win == 2) m_st = M_RUN;
                    else if (win == 0) m_al = (m_al + 1) % 24;
                end
            endcase
        end else if (m_st == M_RUN) begin
            m_idle = 0;
        end else begin
`ifdef MODE_CTRL_TIMEOUT_EN
            m_idle++;
            if (m_idle == 8) begin
                m_st = M_RUN;
                m_idle = 0;
            end
`endif
        end
    endtask

    initial begin
        logic [15:0] tm;
        logic [3:0]  k;
        logic        r;
        int          th, tmn;

        drive(1'b1, 4'd0, 16'h1234);
        tick();
        tick();
        chk_all("reset", VR, 16'h0000, 8'h00, 1'b0);

        // Directed table: applied one row per cycle starting out of reset.
        tbl.push_back(v(4'h0, 16'h1234, VR, 16'h0000, 8'h00, 0));
        tbl.push_back(v(4'h8, 16'h1234, VH, 16'h1234, 8'h00, 0));
        tbl.push_back(v(4'h0, 16'h1234, VH, 16'h1234, 8'h00, 0));
        tbl.push_back(v(4'h8, 16'h1234, VR, 16'h1234, 8'h00, 1));
        tbl.push_back(v(4'h0, 16'h1234, VR, 16'h1234, 8'h00, 0));
        tbl.push_back(v(4'h8, 16'h2259, VH, 16'h2259, 8'h00, 0));
        tbl.push_back(v(4'h0, 16'h2259, VH, 16'h2259, 8'h00, 0));
        tbl.push_back(v(4'h1, 16'h2259, VH, 16'h2359, 8'h00, 0));
        tbl.push_back(v(4'h0, 16'h2259, VH, 16'h2359, 8'h00, 0));
        tbl.push_back(v(4'h1, 16'h2259, VH, 16'h0059, 8'h00, 0));
        tbl.push_back(v(4'h0, 16'h2259, VH, 16'h0059, 8'h00, 0));
        tbl.push_back(v(4'h2, 16'h2259, VM, 16'h0059, 8'h00, 0));
        tbl.push_back(v(4'h0, 16'h2259, VM, 16'h0059, 8'h00, 0));
        tbl.push_back(v(4'h1, 16'h2259, VM, 16'h0000, 8'h00, 0));
        tbl.push_back(v(4'h0, 16'h2259, VM, 16'h0000, 8'h00, 0));
        tbl.push_back(v(4'h8, 16'h2259, VR, 16'h0000, 8'h00, 1));
        tbl.push_back(v(4'h0, 16'h2259, VR, 16'h0000, 8'h00, 0));
        tbl.push_back(v(4'h4, 16'h2259, VA, 16'h0000, 8'h00, 0));
        tbl.push_back(v(4'h0, 16'h2259, VA, 16'h0000, 8'h00, 0));
        tbl.push_back(v(4'h1, 16'h2259, VA, 16'h0000, 8'h01, 0));
        tbl.push_back(v(4'h0, 16'h2259, VA, 16'h0000, 8'h01, 0));
        tbl.push_back(v(4'h1, 16'h2259, VA, 16'h0000, 8'h02, 0));
        tbl.push_back(v(4'h0, 16'h2259, VA, 16'h0000, 8'h02, 0));
        tbl.push_back(v(4'h1, 16'h2259, VA, 16'h0000, 8'h03, 0));
        tbl.push_back(v(4'h0, 16'h2259, VA, 16'h0000, 8'h03, 0));
        tbl.push_back(v(4'h4, 16'h2259, VR, 16'h0000, 8'h03, 0));
        tbl.push_back(v(4'h0, 16'h2259, VR, 16'h0000, 8'h03, 0));
        tbl.push_back(v(4'h8, 16'h2259, VH, 16'h2259, 8'h03, 0));
        tbl.push_back(v(4'h0, 16'h2259, VH, 16'h2259, 8'h03, 0));
        tbl.push_back(v(4'h9, 16'h2259, VR, 16'h2259, 8'h03, 1));
        tbl.push_back(v(4'h0, 16'h2259, VR, 16'h2259, 8'h03, 0));
        tbl.push_back(v(4'h2, 16'h1111, VR, 16'h2259, 8'h03, 0));
        tbl.push_back(v(4'h0, 16'h1111, VR, 16'h2259, 8'h03, 0));
        tbl.push_back(v(4'h1, 16'h1111, VR, 16'h2259, 8'h03, 0));
        tbl.push_back(v(4'h0, 16'h1111, VR, 16'h2259, 8'h03, 0));

        foreach (tbl[i]) begin
            drive(1'b0, tbl[i].k, tbl[i].tm);
            tick();
            chk_all($sformatf("row%0d", i), tbl[i].vw, tbl[i].st,
                    tbl[i].al, tbl[i].ld);
        end

        // Held key_inc for 10 cycles gives a single increment.
        drive(1'b0, 4'h8, 16'h1000);
        tick();
        chk_all("hold enter", VH, 16'h1000, 8'h03, 0);
        drive(1'b0, 4'h0, 16'h1000);
        tick();
        for (int i = 0; i < 10; i++) begin
            drive(1'b0, 4'h1, 16'h1000);
            tick();
        end
        chk_all("hold inc", VH, 16'h1100, 8'h03, 0);

        // Reset mid-edit with key_mode held through release.
        drive(1'b1, 4'h8, 16'h1000);
        tick();
        chk_all("rst mid-edit", VR, 16'h0000, 8'h00, 0);
        drive(1'b0, 4'h8, 16'h1000);
        tick();
        tick();
        chk_all("held thru rst", VR, 16'h0000, 8'h00, 0);
        drive(1'b0, 4'h0, 16'h1000);
        tick();

`ifdef MODE_CTRL_TIMEOUT_EN
        // Idle in SET_MIN returns to RUN after 8 cycles, no load.
        drive(1'b0, 4'h8, 16'h0945);
        tick();
        drive(1'b0, 4'h0, 16'h0945);
        tick();
        drive(1'b0, 4'h2, 16'h0945);
        tick();
        chk_all("to min", VM, 16'h0945, 8'h00, 0);
        for (int i = 1; i <= 8; i++) begin
            drive(1'b0, (i == 1) ? 4'h2 : 4'h0, 16'h0945);
            tick();
            chk_all($sformatf("idle%0d", i), (i == 8) ? VR : VM,
                    16'h0945, 8'h00, 0);
        end
        drive(1'b0, 4'h8, 16'h0945);
        tick();
        chk_all("re-enter", VH, 16'h0945, 8'h00, 0);
        drive(1'b1, 4'h0, 16'h0945);
        tick();
        chk_all("rst in hr", VR, 16'h0000, 8'h00, 0);
        drive(1'b0, 4'h0, 16'h0945);
        tick();
`endif

        // Randomized phase against the model.
        drive(1'b1, 4'h0, 16'h0000);
        m_step(1'b1, 4'h0, 0, 0);
        tick();
        th = 0;
        tmn = 0;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 15) == 0) begin
                th = $urandom_range(0, 23);
                tmn = $urandom_range(0, 59);
            end
            tm = {bcd(th), bcd(tmn)};
            r = ($urandom_range(0, 99) == 0);
            for (int i = 0; i < 4; i++)
                k[i] = ($urandom_range(0, 3) == 0);
            drive(r, k, tm);
            m_step(r, k, th, tmn);
            tick();
            chk_all($sformatf("rnd%0d", c), m_view(),
                    {bcd(m_hr), bcd(m_min)}, bcd(m_al), m_ld);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
